imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction-memory interface: receives a program image as a byte stream
//  (valid/ready), packs bytes into 32-bit instruction words and writes them into inst_mem at
//  consecutive word addresses starting at 0. The PC advances by 1 per instruction, so addresses
//  are word addresses. Holds the pipelined CPU (cpu_hold) until an image is loaded and checked.
// PARAMETERS
//  DEPTH    256   instruction words in inst_mem; max accepted image length
//  ADDR_W   8     width of wr_addr; DEPTH <= 2**ADDR_W
//  TIMEOUT  1024  cycles with in_valid low while receiving before the load is aborted
// PORTS
//  clk        in   1       clock; all state changes on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       1-cycle pulse; begins a load (honoured only in IDLE, DONE, ERR)
//  in_valid   in   1       byte available on in_data
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts in_data this cycle (transfer = in_valid & in_ready)
//  wr_en      out  1       instruction-memory write strobe, 1 cycle per word
//  wr_addr    out  ADDR_W  word address of the write
//  wr_data    out  32      instruction word
//  cpu_hold   out  1       1 = CPU PC/pipeline held; 0 only in DONE
//  busy       out  1       1 in LEN, DATA, WRITE, CHK
//  done       out  1       level, 1 in DONE
//  err        out  1       level, 1 in ERR
//  err_code   out  2       00 none, 01 length > DEPTH, 10 checksum mismatch, 11 timeout
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, busy=0, done=0,
//   err=0, err_code=00. Reset mid-load aborts immediately; words already written stay in memory.
//  Frame: LEN_LO, LEN_HI (N = 16-bit word count), 4*N payload bytes, 1 checksum byte.
//   Each word is packed little-endian: first byte -> [7:0], fourth -> [31:24].
//   Checksum = XOR of all 4*N payload bytes (length bytes excluded).
//  FSM:
//   IDLE  : start -> LEN; clear byte/word counters, checksum, err_code.
//   LEN   : accept 2 bytes. After LEN_HI: N > DEPTH -> ERR(01), no writes; N == 0 -> CHK;
//           otherwise -> DATA.
//   DATA  : accept bytes into shift register; on 4th byte of a word -> WRITE.
//   WRITE : in_ready=0; wr_en=1, wr_addr=word index, wr_data=packed word for exactly 1 cycle.
//           Increment word index; if index == N -> CHK, else -> DATA.
//   CHK   : accept 1 byte; equal to running XOR -> DONE, otherwise -> ERR(10).
//   DONE  : cpu_hold=0, done=1; start -> LEN (cpu_hold re-asserts on the same edge).
//   ERR   : err=1, cpu_hold=1, sticky; start -> LEN.
//  in_ready = 1 in LEN, DATA, CHK; 0 in all other states.
//  Latency: word write occurs the cycle after its 4th byte is accepted; max throughput is 4 bytes
//   per 5 cycles. Final byte accepted in CHK -> DONE/ERR visible on the next cycle.
//  Timeout: counter clears on every transfer and on state entry. In LEN/DATA/CHK, TIMEOUT
//   consecutive cycles without a transfer -> ERR(11). Counter is not active in WRITE.
//  start while busy is ignored. start during a reset cycle is ignored.
//  wr_addr and wr_data hold their last value while wr_en=0.
//  Bytes presented while in_ready=0 are not consumed.
// TESTING
//  1. Reset, start, stream 02 00 | 13 12 11 10 | 23 22 21 20 | chk=00 -> writes addr0=0x10111213,
//     addr1=0x20212223; done=1; cpu_hold=0; err=0.
//  2. Same image with chk=0x01 -> both writes occur, then err=1, err_code=10, cpu_hold=1.
//  3. Length bytes 01 01 (N=257 > DEPTH=256) -> err_code=01 on the next cycle; wr_en never asserted.
//  4. N=1; send 3 payload bytes, then hold in_valid=0 for TIMEOUT cycles -> err_code=11;
//     no write occurs.
//  5. N=0, then chk=00 -> done=1 with zero writes. Toggle in_valid randomly during a 4-word load
//     -> identical writes; in_ready=0 in every WRITE cycle.
//  6. Assert rst_n=0 mid-DATA -> outputs immediately reach reset values. Then start + full
//     frame -> clean load from addr 0. Also: start pulse during DATA is ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and loader status, bundled for imem_loader.
interface imem_loader_if #(
    parameter int unsigned AddrW = 8
) ();
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             wr_en;
    logic [AddrW-1:0] wr_addr;
    logic [31:0]      wr_data;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, err_code
    );

    // Host / stream source side.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, err, err_code
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, XOR-checksummed byte stream, packs
// little-endian 32-bit words and writes them from word address 0, holding the CPU until done.
module imem_loader #(
    parameter int unsigned Depth   = 256,
    parameter int unsigned AddrW   = 8,
    parameter int unsigned Timeout = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_loader_if.slave   bus
);
    localparam int unsigned TmoW = $clog2(Timeout + 1);
    localparam int unsigned IdxW = AddrW + 1;

    typedef enum logic [2:0] {
        StIdle, StLen, StData, StWrite, StChk, StDone, StErr
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]      len_q, len_d;
    logic [IdxW-1:0]  word_idx_q, word_idx_d;
    logic [7:0]       xor_q, xor_d;
    logic [23:0]      sh_q, sh_d;
    logic [AddrW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;

    logic             in_ready;
    logic             xfer;
    logic             active;
    logic [15:0]      len_new;
    logic [IdxW-1:0]  idx_inc;

    assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    assign active   = in_ready;
    assign xfer     = bus.in_valid & in_ready;
    assign len_new  = {bus.in_data, len_q[7:0]};
    assign idx_inc  = word_idx_q + 1'b1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            xor_q      <= '0;
            sh_q       <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_code_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            xor_q      <= xor_d;
            sh_q       <= sh_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_code_q <= err_code_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state: frame parsing, word packing, checksum and inactivity timeout.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        xor_d      = xor_q;
        sh_d       = sh_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_code_d = err_code_q;
        tmo_d      = '0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.start) begin
                    state_d    = StLen;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    xor_d      = '0;
                    err_code_d = 2'b00;
                end
            end
            StLen: begin
                if (xfer) begin
                    if (!byte_cnt_q[0]) begin
                        len_d[7:0] = bus.in_data;
                        byte_cnt_d = 2'd1;
                    end else begin
                        len_d      = len_new;
                        byte_cnt_d = '0;
                        if ({1'b0, len_new} > 17'(Depth)) begin
                            state_d    = StErr;
                            err_code_d = 2'b01;
                        end else if (len_new == 16'd0) begin
                            state_d = StChk;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    xor_d      = xor_q ^ bus.in_data;
                    sh_d       = {bus.in_data, sh_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_data_d = {bus.in_data, sh_q};
                        wr_addr_d = word_idx_q[AddrW-1:0];
                        state_d   = StWrite;
                    end
                end
            end
            StWrite: begin
                word_idx_d = idx_inc;
                state_d    = (16'(idx_inc) == len_q) ? StChk : StData;
            end
            StChk: begin
                if (xfer) begin
                    if (bus.in_data == xor_q) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'b10;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Count idle cycles only while waiting for a byte; any transfer or state change clears.
        if (active && !xfer && (state_d == state_q)) begin
            if (tmo_q == TmoW'(Timeout - 1)) begin
                state_d    = StErr;
                err_code_d = 2'b11;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // Outputs decoded from state; write port driven from registers so it holds between writes.
    always_comb begin
        bus.in_ready = in_ready;
        bus.wr_en    = (state_q == StWrite);
        bus.wr_addr  = wr_addr_q;
        bus.wr_data  = wr_data_q;
        bus.cpu_hold = (state_q != StDone);
        bus.busy     = (state_q == StLen) || (state_q == StData) ||
                       (state_q == StWrite) || (state_q == StChk);
        bus.done     = (state_q == StDone);
        bus.err      = (state_q == StErr);
        bus.err_code = err_code_q;
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete frames plus timeout, random-gap,
// start-while-busy and mid-load reset sequences.
module tb_imem_loader;
    localparam int unsigned Timeout = 1024;

    logic clk;
    logic rst_n;

    imem_loader_if #(.AddrW(8)) bus ();

    imem_loader #(
        .Depth   (256),
        .AddrW   (8),
        .Timeout (Timeout)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Capture every write; in_ready must be low whenever a write is issued.
    always @(posedge clk) begin
        if (rst_n && bus.wr_en) begin
            wa.push_back(bus.wr_addr);
            wd.push_back(bus.wr_data);
            check("in_ready_in_write", 32'(bus.in_ready), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
        check({tag, "_wr_data"},  bus.wr_data,       32'd0);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd1);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_err"},      32'(bus.err),      32'd0);
        check({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
    endtask

    // Frame bytes are listed in send order, right-aligned; expected words likewise.
    typedef struct packed {
        logic [159:0] bytes;
        logic [7:0]   nbytes;
        logic [127:0] words;
        logic [7:0]   nwr;
        logic         exp_done;
        logic [1:0]   exp_code;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{88'h02_00_13_12_11_10_23_22_21_20_00, 8'd11,
                    64'h10111213_20212223, 8'd2, 1'b1, 2'b00};
        vecs[1] = '{88'h02_00_13_12_11_10_23_22_21_20_01, 8'd11,
                    64'h10111213_20212223, 8'd2, 1'b0, 2'b10};
        vecs[2] = '{16'h01_01, 8'd2, 128'd0, 8'd0, 1'b0, 2'b01};
        vecs[3] = '{24'h00_00_00, 8'd3, 128'd0, 8'd0, 1'b1, 2'b00};
        vecs[4] = '{56'h01_00_EF_BE_AD_DE_22, 8'd7, 32'hDEADBEEF, 8'd1, 1'b1, 2'b00};
        vecs[5] = '{24'h00_00_5A, 8'd3, 128'd0, 8'd0, 1'b0, 2'b10};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;                // start during reset must be ignored
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        for (int v = 0; v < 6; v++) begin
            wa.delete();
            wd.delete();
            pulse_start();
            check($sformatf("v%0d_busy_after_start", v), 32'(bus.busy), 32'd1);
            for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
                send_byte(vecs[v].bytes[(int'(vecs[v].nbytes) - 1 - i) * 8 +: 8]);
            end
            check($sformatf("v%0d_done", v), 32'(bus.done), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_err", v), 32'(bus.err), 32'(!vecs[v].exp_done));
            check($sformatf("v%0d_err_code", v), 32'(bus.err_code), 32'(vecs[v].exp_code));
            check($sformatf("v%0d_cpu_hold", v), 32'(bus.cpu_hold), 32'(!vecs[v].exp_done));
            check($sformatf("v%0d_busy", v), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_nwr", v), 32'(wa.size()), 32'(vecs[v].nwr));
            for (int k = 0; k < int'(vecs[v].nwr) && k < wa.size(); k++) begin
                check($sformatf("v%0d_addr%0d", v, k), 32'(wa[k]), k);
                check($sformatf("v%0d_data%0d", v, k), wd[k],
                      vecs[v].words[(int'(vecs[v].nwr) - 1 - k) * 32 +: 32]);
            end
        end

        // Timeout: N=1, three payload bytes, then silence.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        repeat (Timeout - 1) @(posedge clk);
        @(negedge clk);
        check("tmo_err_before", 32'(bus.err), 32'd0);
        check("tmo_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("tmo_err", 32'(bus.err), 32'd1);
        check("tmo_err_code", 32'(bus.err_code), 32'd3);
        check("tmo_nwr", 32'(wa.size()), 32'd0);

        // Four-word load with random valid gaps.
        begin
            logic [31:0] w[4];
            logic [7:0]  cs;
            w[0] = 32'h03020100; w[1] = 32'hA5A5_5A5A; w[2] = 32'hFFFF0000; w[3] = 32'h12345678;
            cs = 8'h00;
            wa.delete();
            wd.delete();
            pulse_start();
            send_byte(8'h04);
            send_byte(8'h00);
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 4; b++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send_byte(w[k][b*8 +: 8]);
                    cs = cs ^ w[k][b*8 +: 8];
                end
            end
            send_byte(cs);
            check("rnd_done", 32'(bus.done), 32'd1);
            check("rnd_nwr", 32'(wa.size()), 32'd4);
            for (int k = 0; k < 4 && k < wa.size(); k++) begin
                check($sformatf("rnd_addr%0d", k), 32'(wa[k]), k);
                check($sformatf("rnd_data%0d", k), wd[k], w[k]);
            end
            check("rnd_hold_addr", 32'(bus.wr_addr), 32'd3);
            check("rnd_hold_data", bus.wr_data, 32'h12345678);
        end

        // Start pulse in the middle of DATA is ignored.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        pulse_start();
        check("busy_start_busy", 32'(bus.busy), 32'd1);
        send_byte(8'h22);
        send_byte(8'h11);
        send_byte(8'h44 ^ 8'h33 ^ 8'h22 ^ 8'h11);
        check("busy_start_done", 32'(bus.done), 32'd1);
        check("busy_start_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) check("busy_start_data", wd[0], 32'h11223344);

        // Reset in the middle of the third word, then a clean reload.
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i));
        check("pre_rst_wr_addr", 32'(bus.wr_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
        check("reload_done", 32'(bus.done), 32'd1);
        check("reload_cpu_hold", 32'(bus.cpu_hold), 32'd0);
        check("reload_nwr", 32'(wa.size()), 32'd1);
        if (wa.size() > 0) begin
            check("reload_addr", 32'(wa[0]), 32'd0);
            check("reload_data", wd[0], 32'h12345678);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
